// File: rtl/apuf_eval_ctrl.sv
// -----------------------------------------------------------------------------
// apuf_eval_ctrl
//
// Evaluation controller for one arbiter-PUF delay line. It latches a challenge,
// fires the launch edge into the line NUM_EVALS times, samples the synchronised
// arbiter bit after each launch and majority-votes the samples. The result is
// returned as one response bit plus the ones-count, through a valid/ready
// handshake.
//
// Ports
//   clk            in   system clock
//   rst            in   synchronous, active-high reset
//   start          in   evaluation request, accepted when start && ready
//   challenge_in   in   challenge, sampled on accept
//   ready          out  high only while idle
//   challenge_out  out  latched challenge driving the delay-line selects
//   launch         out  launch edge into both delay-line paths
//   arb_clr        out  arbiter clear, high for the whole settle phase
//   arb_in         in   arbiter output (asynchronous to clk)
//   resp_valid     out  response available
//   resp_ready     in   consumer accept
//   response       out  majority vote (ones_count > NUM_EVALS/2)
//   ones_count     out  number of evaluations that sampled 1
// -----------------------------------------------------------------------------
module apuf_eval_ctrl #(
    parameter int LINE_LENGTH   = 64,
    parameter int NUM_EVALS     = 15,
    parameter int SETTLE_CYCLES = 8,
    parameter int LAUNCH_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [LINE_LENGTH-1:0]         challenge_in,
    output logic                           ready,
    output logic [LINE_LENGTH-1:0]         challenge_out,
    output logic                           launch,
    output logic                           arb_clr,
    input  logic                           arb_in,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic                           response,
    output logic [$clog2(NUM_EVALS+1)-1:0] ones_count
);

    localparam int CW = $clog2(NUM_EVALS + 1);
    localparam int PHASE_MAX = (SETTLE_CYCLES > LAUNCH_CYCLES) ? SETTLE_CYCLES : LAUNCH_CYCLES;
    localparam int PW = $clog2(PHASE_MAX + 1);

    localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] LAUNCH_LAST = PW'(LAUNCH_CYCLES - 1);
    localparam logic [CW-1:0] EVALS_LAST  = CW'(NUM_EVALS - 1);
    localparam logic [CW-1:0] HALF        = CW'(NUM_EVALS / 2);

    // One-hot encoding: launch, arb_clr, ready and resp_valid are each a
    // single flop output. launch clocks the delay line, so it must not be a
    // decoded (potentially glitching) function of several state bits.
    localparam int S_IDLE   = 0;
    localparam int S_SETUP  = 1;
    localparam int S_LAUNCH = 2;
    localparam int S_DONE   = 3;

    localparam logic [3:0] IDLE   = 4'b0001;
    localparam logic [3:0] SETUP  = 4'b0010;
    localparam logic [3:0] LAUNCH = 4'b0100;
    localparam logic [3:0] DONE   = 4'b1000;

    logic [3:0]             state_reg;
    logic [3:0]             state_next;
    logic [PW-1:0]          phase_reg;
    logic [CW-1:0]          eval_reg;
    logic [CW-1:0]          ones_reg;
    logic [CW-1:0]          count_out_reg;
    logic                   response_reg;
    logic [LINE_LENGTH-1:0] challenge_reg;
    logic [SYNC_STAGES-1:0] sync_reg;

    logic          accept;
    logic          setup_last;
    logic          sample;
    logic          last_eval;
    logic [CW-1:0] ones_sum;

    assign accept     = state_reg[S_IDLE] && start;
    assign setup_last = state_reg[S_SETUP] && (phase_reg == SETTLE_LAST);
    // Last launch cycle: the arbiter has had LAUNCH_CYCLES-1 edges to pass
    // through the synchroniser, so the sample reflects this evaluation.
    assign sample     = state_reg[S_LAUNCH] && (phase_reg == LAUNCH_LAST);
    assign last_eval  = (eval_reg == EVALS_LAST);
    assign ones_sum   = ones_reg + CW'(sync_reg[SYNC_STAGES-1]);

    // Synchroniser for the asynchronous arbiter output.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], arb_in};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (start)      state_next = SETUP;
            SETUP:   if (setup_last) state_next = LAUNCH;
            LAUNCH:  if (sample)     state_next = last_eval ? DONE : SETUP;
            DONE:    if (resp_ready) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Outputs taken straight from the one-hot state flops.
    always_comb begin
        ready      = state_reg[S_IDLE];
        arb_clr    = state_reg[S_SETUP];
        launch     = state_reg[S_LAUNCH];
        resp_valid = state_reg[S_DONE];
    end

    // Datapath: phase timer, evaluation/ones counters, result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg     <= '0;
            eval_reg      <= '0;
            ones_reg      <= '0;
            count_out_reg <= '0;
            response_reg  <= 1'b0;
            challenge_reg <= '0;
        end else begin
            // Phase timer restarts at every SETUP/LAUNCH boundary.
            if ((state_reg[S_SETUP] && !setup_last) || (state_reg[S_LAUNCH] && !sample)) begin
                phase_reg <= phase_reg + PW'(1);
            end else begin
                phase_reg <= '0;
            end

            if (accept) begin
                challenge_reg <= challenge_in;
                eval_reg      <= '0;
                ones_reg      <= '0;
                count_out_reg <= '0;
                response_reg  <= 1'b0;
            end

            if (sample) begin
                ones_reg <= ones_sum;
                eval_reg <= eval_reg + CW'(1);
                // Result is captured on the transition into DONE and then held.
                if (last_eval) begin
                    count_out_reg <= ones_sum;
                    response_reg  <= (ones_sum > HALF);
                end
            end
        end
    end

    assign challenge_out = challenge_reg;
    assign response      = response_reg;
    assign ones_count    = count_out_reg;

endmodule
